// File: rtl/buffered_fifo.sv
// buffered_fifo: first-word-fall-through FIFO over a RAM with a 2-cycle registered read.
// A 3-entry prefetch buffer hides the read latency so the head can be popped every cycle.
module buffered_fifo #(
   parameter int p_addresswidth = 4,
   parameter int p_datawidth    = 16,
   parameter int p_almostfull   = 2**p_addresswidth-2,
   parameter int p_almostempty  = 2
) (
   input  logic                      inclk,
   input  logic                      inrstn,
   input  logic                      in_flush,
   input  logic                      in_wren,
   input  logic [p_datawidth-1:0]    in_wrdata,
   input  logic                      in_ready,
   output logic                      out_valid,
   output logic [p_datawidth-1:0]    out_data,
   output logic [p_addresswidth:0]   out_usedw,
   output logic                      out_full,
   output logic                      out_empty,
   output logic                      out_almostfull,
   output logic                      out_almostempty,
   output logic                      out_overflow
);
   localparam int AW = p_addresswidth;
   localparam int DW = p_datawidth;
   localparam logic [AW:0] CAP = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] AF  = (AW+1)'(p_almostfull);
   localparam logic [AW:0] AE  = (AW+1)'(p_almostempty);

   logic [DW-1:0] mem [2**AW];
   logic [AW-1:0] wrptr_q, wrptr_d, rdptr_q, rdptr_d;
   logic [AW:0]   usedw_q, usedw_d, ramcnt_q, ramcnt_d;
   logic          rv1_q, rv1_d, rv2_q, rv2_d;
   logic [DW-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
   logic [DW-1:0] pb_q [3];
   logic [DW-1:0] pb_d [3];
   logic [1:0]    pcnt_q, pcnt_d, slot;
   logic          valid_q, valid_d, full_q, full_d, empty_q, empty_d;
   logic          af_q, af_d, ae_q, ae_d, ovf_q, ovf_d;
   logic          wr, pop, issue;
   logic [2:0]    occ;

   always_comb begin
      wr       = in_wren & ~full_q & ~in_flush;
      pop      = valid_q & in_ready & ~in_flush;
      // Occupancy net of this cycle's pop, so a steady stream keeps three words in motion.
      occ      = {1'b0, pcnt_q} + {2'b0, rv1_q} + {2'b0, rv2_q} - {2'b0, pop};
      issue    = (ramcnt_q != '0) && (occ < 3'd3) && !in_flush;
      slot     = pcnt_q - {1'b0, pop};
      wrptr_d  = wrptr_q + AW'(wr);
      rdptr_d  = rdptr_q + AW'(issue);
      ramcnt_d = ramcnt_q + (AW+1)'(wr) - (AW+1)'(issue);
      usedw_d  = usedw_q + (AW+1)'(wr) - (AW+1)'(pop);
      rv1_d    = issue;
      rv2_d    = rv1_q & ~in_flush;
      rd1_d    = issue ? mem[rdptr_q] : rd1_q;
      rd2_d    = rd1_q;
      pcnt_d   = pcnt_q + {1'b0, rv2_q} - {1'b0, pop};
      pb_d     = pb_q;
      if (pop) begin
         pb_d[0] = pb_q[1];
         pb_d[1] = pb_q[2];
      end
      if (rv2_q) pb_d[slot] = rd2_q;
      ovf_d    = ovf_q | (in_wren & full_q);
      if (in_flush) begin
         wrptr_d  = '0;
         rdptr_d  = '0;
         ramcnt_d = '0;
         usedw_d  = '0;
         pcnt_d   = '0;
         pb_d     = '{default: '0};
         ovf_d    = 1'b0;
      end
      valid_d  = pcnt_d != '0;
      full_d   = usedw_d == CAP;
      empty_d  = usedw_d == '0;
      af_d     = usedw_d >= AF;
      ae_d     = usedw_d <= AE;
   end

   always_ff @(posedge inclk) begin
      if (wr) mem[wrptr_q] <= in_wrdata;
   end

   always_ff @(posedge inclk or negedge inrstn) begin
      if (!inrstn) begin
         wrptr_q  <= '0;
         rdptr_q  <= '0;
         ramcnt_q <= '0;
         usedw_q  <= '0;
         rv1_q    <= 1'b0;
         rv2_q    <= 1'b0;
         rd1_q    <= '0;
         rd2_q    <= '0;
         pcnt_q   <= '0;
         pb_q     <= '{default: '0};
         valid_q  <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         af_q     <= 1'b0;
         ae_q     <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wrptr_q  <= wrptr_d;
         rdptr_q  <= rdptr_d;
         ramcnt_q <= ramcnt_d;
         usedw_q  <= usedw_d;
         rv1_q    <= rv1_d;
         rv2_q    <= rv2_d;
         rd1_q    <= rd1_d;
         rd2_q    <= rd2_d;
         pcnt_q   <= pcnt_d;
         pb_q     <= pb_d;
         valid_q  <= valid_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         af_q     <= af_d;
         ae_q     <= ae_d;
         ovf_q    <= ovf_d;
      end
   end

   assign out_valid       = valid_q;
   assign out_data        = pb_q[0];
   assign out_usedw       = usedw_q;
   assign out_full        = full_q;
   assign out_empty       = empty_q;
   assign out_almostfull  = af_q;
   assign out_almostempty = ae_q;
   assign out_overflow    = ovf_q;
endmodule

// File: tb/tb_buffered_fifo.sv
// tb_buffered_fifo: randomized and directed stimulus; a negedge monitor keeps a queue model
// of the FIFO contents and checks popped data and every flag against it each cycle.
module tb_buffered_fifo;
   localparam int DW = 16;
   localparam int C  = 16;
   localparam int AF = 14;
   localparam int AE = 2;

   logic          inclk = 1'b0, inrstn = 1'b0, in_flush = 1'b0, in_wren = 1'b0, in_ready = 1'b0;
   logic [DW-1:0] in_wrdata = '0;
   logic          out_valid, out_full, out_empty, out_almostfull, out_almostempty, out_overflow;
   logic [DW-1:0] out_data;
   logic [4:0]    out_usedw;

   buffered_fifo #(.p_addresswidth(4), .p_datawidth(DW), .p_almostfull(AF), .p_almostempty(AE)) dut (
      .inclk(inclk), .inrstn(inrstn), .in_flush(in_flush), .in_wren(in_wren), .in_wrdata(in_wrdata),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_usedw(out_usedw),
      .out_full(out_full), .out_empty(out_empty), .out_almostfull(out_almostfull),
      .out_almostempty(out_almostempty), .out_overflow(out_overflow));

   always #5 inclk = ~inclk;

   int            chk = 0, err = 0, n_acc = 0;
   logic [DW-1:0] exp_q[$];
   logic          m_ovf = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: queue of words held; judges each upcoming edge from the inputs seen mid-cycle.
   always @(negedge inclk) begin
      if (inrstn) begin
         int sz;
         sz = exp_q.size();
         check("usedw", 32'(out_usedw), sz);
         check("full", out_full, sz == C);
         check("empty", out_empty, sz == 0);
         check("almostfull", out_almostfull, sz >= AF);
         check("almostempty", out_almostempty, sz <= AE);
         check("overflow", out_overflow, m_ovf);
         if (sz == 0) check("valid_when_empty", out_valid, 0);
         if (in_flush) begin
            exp_q.delete();
            m_ovf = 1'b0;
         end else begin
            if (out_valid && in_ready && sz > 0) check("pop_data", out_data, exp_q.pop_front());
            if (in_wren) begin
               if (sz == C) m_ovf = 1'b1;
               else begin
                  exp_q.push_back(in_wrdata);
                  n_acc++;
               end
            end
         end
      end
   end

   task automatic tick;
      @(posedge inclk);
      #1;
   endtask

   task automatic wait_empty(input string nm);
      int n = 0;
      while (!(out_empty && !out_valid) && n < 100) begin
         tick();
         n++;
      end
      check(nm, out_empty, 1);
   endtask

   task automatic write_n(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         in_wren   = 1'b1;
         in_wrdata = DW'(base + i);
         tick();
      end
      in_wren = 1'b0;
   endtask

   initial begin
      int bub, pops, start, budget;
      bit started;
      repeat (3) @(posedge inclk);
      #1 inrstn = 1'b1;
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_usedw", 32'(out_usedw), 0);
      check("rst_empty", out_empty, 1);
      check("rst_almostempty", out_almostempty, 1);
      check("rst_overflow", out_overflow, 0);

      in_ready = 1'b1; in_wren = 1'b1; in_wrdata = 16'h0001;
      tick();
      in_wren = 1'b0;
      check("lat_usedw1", 32'(out_usedw), 1);
      tick(); check("lat_e1_valid", out_valid, 0);
      tick(); check("lat_e2_valid", out_valid, 0);
      tick(); check("lat_e3_valid", out_valid, 1);
      check("lat_e3_data", out_data, 16'h0001);
      tick(); check("lat_pop_valid", out_valid, 0);
      check("lat_usedw0", 32'(out_usedw), 0);
      check("lat_empty", out_empty, 1);

      in_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         in_wren = 1'b1; in_wrdata = DW'(i);
         tick();
         check("fill_af_edge", out_almostfull, i >= 13);
      end
      in_wren = 1'b0;
      check("fill_full", out_full, 1);
      check("fill_usedw", 32'(out_usedw), 16);
      check("fill_overflow", out_overflow, 1);
      in_ready = 1'b1;
      wait_empty("fill_drain");
      in_ready = 1'b0;

      in_flush = 1'b1; tick(); in_flush = 1'b0;
      check("flush_clears_ovf", out_overflow, 0);
      write_n(16, 16'h0200);
      repeat (4) tick();
      check("fp_full", out_full, 1);
      check("fp_valid", out_valid, 1);
      in_wren = 1'b1; in_ready = 1'b1; in_wrdata = 16'hBEEF;
      tick();
      in_wren = 1'b0; in_ready = 1'b0;
      check("fp_overflow", out_overflow, 1);
      check("fp_usedw", 32'(out_usedw), 15);
      in_ready = 1'b1;
      wait_empty("fp_drain");

      bub = 0; pops = 0; started = 0;
      for (int cyc = 0; cyc < 100 && pops < 40; cyc++) begin
         in_wren   = cyc < 40;
         in_wrdata = DW'($urandom);
         tick();
         if (started || out_valid) begin
            started = 1;
            if (out_valid) pops++;
            else bub++;
         end
      end
      in_wren = 1'b0;
      check("stream_bubbles", bub, 0);
      check("stream_pops", pops, 40);
      wait_empty("stream_drain");

      in_ready = 1'b0;
      write_n(16, 16'h0300);
      in_wren = 1'b1; tick(); in_wren = 1'b0;
      in_ready = 1'b1; repeat (12) tick(); in_ready = 1'b0;
      write_n(5, 16'h0100);
      in_flush = 1'b1; tick(); in_flush = 1'b0;
      check("flush_valid", out_valid, 0);
      check("flush_usedw", 32'(out_usedw), 0);
      check("flush_overflow", out_overflow, 0);
      check("flush_empty", out_empty, 1);
      in_ready = 1'b1; in_wren = 1'b1; in_wrdata = 16'h00AA;
      tick();
      in_wren = 1'b0;
      tick(); check("post_flush_e1", out_valid, 0);
      tick(); check("post_flush_e2", out_valid, 0);
      tick(); check("post_flush_e3", out_valid, 1);
      check("post_flush_data", out_data, 16'h00AA);
      wait_empty("post_flush_drain");

      start = n_acc; budget = 0;
      while (n_acc - start < 1000 && budget < 20000) begin
         in_wren   = ($urandom % 100) < 60;
         in_wrdata = DW'($urandom);
         in_ready  = $urandom % 2;
         tick();
         budget++;
      end
      in_wren = 1'b0;
      check("rand_words_done", n_acc - start >= 1000, 1);
      in_ready = 1'b1;
      wait_empty("rand_drain");
      check("rand_model_empty", exp_q.size(), 0);
      tick();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end
endmodule
